// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a length/words/XOR-checksum byte
// stream, writes each assembled word to imem and releases the core on a clean load.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [31:0]       imem_addr_o,
    output logic [31:0]       imem_wd_o,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

    function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_s;
    logic [15:0]       len_full_s;
    logic              len_bad_s;
    logic              last_word_s;
    logic              csum_ok_s;

    assign accept_s    = rx_valid_i && rx_ready_o;
    assign len_full_s  = {rx_data_i, len_q[7:0]};
    assign len_bad_s   = (len_full_s == 16'd0) || ({1'b0, len_full_s} > MAX_WORDS);
    assign last_word_s = ((32'(word_cnt_q) + 32'd1) == 32'(len_q));
    assign csum_ok_s   = (xor_q == rx_data_i);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in the resting states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) state_d = S_LEN;
                else         state_d = state_q;
            end
            S_LEN: begin
                if (accept_s && byte_cnt_q[0]) state_d = len_bad_s ? S_ERR : S_DATA;
                else                           state_d = S_LEN;
            end
            S_DATA: begin
                if (accept_s && (byte_cnt_q == 2'd3) && last_word_s) state_d = S_CSUM;
                else                                                 state_d = S_DATA;
            end
            S_CSUM: begin
                if (accept_s) state_d = csum_ok_s ? S_DONE : S_ERR;
                else          state_d = S_CSUM;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: length capture, word assembly, checksum and write pulse.
    always_comb begin
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wd_d       = wd_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    len_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    asm_d      = 32'd0;
                    xor_d      = 8'd0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end else begin
                    done_d     = done_q;
                end
            end
            S_LEN: begin
                if (accept_s) begin
                    if (byte_cnt_q[0]) begin
                        len_d      = len_full_s;
                        byte_cnt_d = 2'd0;
                        err_d      = len_bad_s;
                    end else begin
                        len_d[7:0] = rx_data_i;
                        byte_cnt_d = 2'd1;
                    end
                end else begin
                    len_d = len_q;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    xor_d      = csum_upd(xor_q, rx_data_i);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = 32'({word_cnt_q, 2'b00});
                        wd_d       = {rx_data_i, asm_q[23:0]};
                        word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        we_d       = 1'b0;
                    end
                end else begin
                    asm_d = asm_q;
                end
            end
            S_CSUM: begin
                if (accept_s) begin
                    done_d = csum_ok_s;
                    err_d  = !csum_ok_s;
                end else begin
                    done_d = done_q;
                end
            end
            default: begin
                we_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            asm_q      <= 32'd0;
            xor_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wd_q       <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Output decode from the state register; rx_ready stays up through write pulses.
    always_comb begin
        rx_ready_o = 1'b0;
        busy_o     = 1'b0;
        core_rst_o = 1'b0;
        case (state_q)
            S_LEN, S_DATA, S_CSUM: begin
                rx_ready_o = 1'b1;
                busy_o     = 1'b1;
            end
            S_DONE: begin
                core_rst_o = 1'b1;
            end
            default: begin
                rx_ready_o = 1'b0;
            end
        endcase
    end

    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_wd_o      = wd_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs change on the falling edge, outputs are
// sampled on the falling edge, and writes are logged by a falling-edge monitor.
module tb_imem_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wd;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls  = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  frame[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wd_o(imem_wd),
        .core_rst_o(core_rst), .busy_o(busy), .done_o(done), .err_o(err),
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int tries;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        tries    = 0;
        while ((rx_ready !== 1'b1) && (tries < 20)) begin
            @(negedge clk);
            tries++;
            stalls++;
        end
        if (tries >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte: rx_ready got %b want 1 within 20 cycles", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input bit gaps, input int start_at);
        stalls = 0;
        for (int i = 0; i < frame.size(); i++) begin
            if (i == start_at) begin
                rx_valid = 1'b0;
                do_start();
            end
            send_byte(frame[i], gaps);
        end
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic check_good_writes(input string tag);
        n_tests++;
        if (wr_addr.size() !== 2) begin
            n_fail++;
            $display("FAIL %s_nwrites: got %0d want 2", tag, wr_addr.size());
        end
        n_tests++;
        if ({wr_addr[0], wr_data[0]} !== {32'h0000_0000, 32'h0050_0513}) begin
            n_fail++;
            $display("FAIL %s_word0: got %h/%h want 00000000/00500513", tag, wr_addr[0], wr_data[0]);
        end
        n_tests++;
        if ({wr_addr[1], wr_data[1]} !== {32'h0000_0004, 32'h00A0_0593}) begin
            n_fail++;
            $display("FAIL %s_word1: got %h/%h want 00000004/00a00593", tag, wr_addr[1], wr_data[1]);
        end
        n_tests++;
        if (words_loaded !== 11'd2) begin
            n_fail++;
            $display("FAIL %s_words_loaded: got %0d want 2", tag, words_loaded);
        end
    endtask

    task automatic check_done_state(input string tag);
        n_tests++;
        if ({done, err, core_rst, rx_ready, busy, imem_we} !== 6'b101000) begin
            n_fail++;
            $display("FAIL %s_final: {done,err,core_rst,rx_ready,busy,we} got %b want 101000",
                     tag, {done, err, core_rst, rx_ready, busy, imem_we});
        end
    endtask

    task automatic test_reset();
        start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rst_n = 1'b1;
        #13;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rx_ready, imem_we, imem_addr, imem_wd, core_rst, busy, done, err, words_loaded} !== 81'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h want 0",
                     {rx_ready, imem_we, imem_addr, imem_wd, core_rst, busy, done, err, words_loaded});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rx_valid = 1'b1; rx_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rx_ready, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_ready: {rx_ready,busy} got %b want 00", {rx_ready, busy});
            end
        end
        rx_valid = 1'b0;
        #1;
        n_tests++;
        if (wr_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_writes: got %0d want 0", wr_addr.size());
        end
    endtask

    task automatic test_good_load();
        clear_log();
        @(negedge clk);
        do_start();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h70};
        send_frame(1'b0, -1);
        check_good_writes("good");
        check_done_state("good");
        n_tests++;
        if (stalls !== 0) begin
            n_fail++;
            $display("FAIL good_full_rate: stall cycles got %0d want 0", stalls);
        end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        @(negedge clk);
        do_start();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h71};
        send_frame(1'b0, -1);
        check_good_writes("badcs");
        n_tests++;
        if ({done, err, core_rst, busy} !== 4'b0100) begin
            n_fail++;
            $display("FAIL badcs_final: {done,err,core_rst,busy} got %b want 0100", {done, err, core_rst, busy});
        end
    endtask

    task automatic test_bad_length();
        clear_log();
        @(negedge clk);
        do_start();
        frame = '{8'h00, 8'h00};
        send_frame(1'b0, -1);
        n_tests++;
        if ({done, err, busy, rx_ready} !== 4'b0100) begin
            n_fail++;
            $display("FAIL len_zero: {done,err,busy,rx_ready} got %b want 0100", {done, err, busy, rx_ready});
        end
        @(negedge clk);
        do_start();
        frame = '{8'h01, 8'h04};
        send_frame(1'b0, -1);
        n_tests++;
        if ({done, err, busy, rx_ready} !== 4'b0100) begin
            n_fail++;
            $display("FAIL len_1025: {done,err,busy,rx_ready} got %b want 0100", {done, err, busy, rx_ready});
        end
        @(negedge clk);
        do_start();
        frame = '{8'h00, 8'h04};
        send_frame(1'b0, -1);
        n_tests++;
        if ({err, busy, rx_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL len_1024: {err,busy,rx_ready} got %b want 011", {err, busy, rx_ready});
        end
        n_tests++;
        if (wr_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL len_writes: got %0d want 0", wr_addr.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_flow_control();
        clear_log();
        @(negedge clk);
        do_start();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h70};
        send_frame(1'b1, 5);
        check_good_writes("flow");
        check_done_state("flow");
    endtask

    task automatic test_reset_mid_data();
        clear_log();
        @(negedge clk);
        do_start();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05};
        send_frame(1'b0, -1);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rx_ready, imem_we, imem_addr, imem_wd, core_rst, busy, done, err, words_loaded} !== 81'd0) begin
            n_fail++;
            $display("FAIL middata_reset: got %h want 0",
                     {rx_ready, imem_we, imem_addr, imem_wd, core_rst, busy, done, err, words_loaded});
        end
        n_tests++;
        if ((wr_addr.size() !== 1) || (wr_data[0] !== 32'h0050_0513)) begin
            n_fail++;
            $display("FAIL middata_partial: writes got %0d want 1 (word0)", wr_addr.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);
        do_start();
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h70};
        send_frame(1'b0, -1);
        check_good_writes("restart");
        check_done_state("restart");
        // Restart from DONE: the core must be held in reset again straight away.
        clear_log();
        @(negedge clk);
        do_start();
        n_tests++;
        if ({core_rst, busy, done} !== 3'b010) begin
            n_fail++;
            $display("FAIL done_restart: {core_rst,busy,done} got %b want 010", {core_rst, busy, done});
        end
        frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_frame(1'b0, -1);
        n_tests++;
        if ((wr_addr.size() !== 1) || ({wr_addr[0], wr_data[0]} !== {32'h0, 32'hDEAD_BEEF})) begin
            n_fail++;
            $display("FAIL reload_write: n=%0d got %h/%h want 00000000/deadbeef",
                     wr_addr.size(), wr_addr[0], wr_data[0]);
        end
        n_tests++;
        if ({done, err, core_rst, words_loaded} !== {3'b101, 11'd1}) begin
            n_fail++;
            $display("FAIL reload_final: {done,err,core_rst} got %b words %0d want 101 words 1",
                     {done, err, core_rst}, words_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_bad_length();
        test_flow_control();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
